// File: rtl/field_lock.sv
// Lock unit: merges the falling 4x4 block into the occupancy field, then removes full rows.
// Playable cells are stored; the wall column and floor row are tied to 1 on the output.
module field_lock #(
   parameter int unsigned ROWS  = 20,
   parameter int unsigned COLS  = 10,
   parameter int unsigned COL_W = 4,
   parameter int unsigned ROW_W = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           lock_req,
   input  logic                           clear_req,
   input  logic [15:0]                    b_mask,
   input  logic [COL_W:0]                 b_x,
   input  logic [ROW_W:0]                 b_y,
   output logic [(ROWS+1)*(COLS+1)-1:0]   field_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [2:0]                     lines_o,
   output logic                           game_over_o
);

   localparam logic [ROW_W:0]   RowLim  = (ROW_W+1)'(ROWS);
   localparam logic [COL_W:0]   ColLim  = (COL_W+1)'(COLS);
   localparam logic [ROW_W-1:0] PtrLast = ROW_W'(ROWS - 1);

   typedef enum logic [2:0] {StIdle, StMerge, StScan, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [15:0]      mask_q, mask_d;
   logic [COL_W:0]   x_q, x_d;
   logic [ROW_W:0]   y_q, y_d;
   logic [3:0]       k_q, k_d;
   logic [ROW_W-1:0] ptr_q, ptr_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [2:0]       lines_q, lines_d;
   logic             over_q, over_d;
   logic [COLS-1:0]  rows_q [ROWS];
   logic [COLS-1:0]  rows_d [ROWS];

   // Brick target cell, one bit wider than the origin so the offset never wraps.
   logic signed [ROW_W+1:0] r_s;
   logic signed [COL_W+1:0] c_s;
   logic [ROW_W:0]          r_u;
   logic [COL_W:0]          c_u;
   logic                    r_ok, c_ok;

   always_comb begin
      r_s  = $signed({y_q[ROW_W], y_q}) + $signed({{ROW_W{1'b0}}, k_q[3:2]});
      c_s  = $signed({x_q[COL_W], x_q}) + $signed({{COL_W{1'b0}}, k_q[1:0]});
      r_u  = r_s[ROW_W:0];
      c_u  = c_s[COL_W:0];
      r_ok = !r_s[ROW_W+1] && (r_u < RowLim);
      c_ok = !c_s[COL_W+1] && (c_u < ColLim);
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      lines_d = lines_q;
      over_d  = over_q;
      rows_d  = rows_q;

      unique case (state_q)
         StIdle: begin
            if (lock_req) begin
               mask_d  = b_mask;
               x_d     = b_x;
               y_d     = b_y;
               k_d     = 4'd0;
               cnt_d   = 3'd0;
               state_d = StMerge;
            end
         end
         StMerge: begin
            if (mask_q[k_q]) begin
               if (r_s[ROW_W+1]) begin
                  over_d = 1'b1;
               end else if (r_ok && c_ok) begin
                  rows_d[r_u[ROW_W-1:0]][c_u[COL_W-1:0]] = 1'b1;
               end
            end
            k_d = k_q + 4'd1;
            if (k_q == 4'd15) begin
               ptr_d   = PtrLast;
               state_d = StScan;
            end
         end
         StScan: begin
            if (&rows_q[ptr_q]) begin
               state_d = StShift;
            end else if (ptr_q == '0) begin
               lines_d = cnt_q;
               state_d = StDone;
            end else begin
               ptr_d = ptr_q - 1'b1;
            end
         end
         StShift: begin
            // Pointer is kept so the row that dropped into place is checked again.
            for (int r = 1; r < ROWS; r++) begin
               if (ROW_W'(r) <= ptr_q) rows_d[r] = rows_q[r-1];
            end
            rows_d[0] = '0;
            cnt_d     = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
            state_d   = StScan;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (clear_req) begin
         state_d = StIdle;
         cnt_d   = 3'd0;
         lines_d = 3'd0;
         over_d  = 1'b0;
         for (int r = 0; r < ROWS; r++) rows_d[r] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mask_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         k_q     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         lines_q <= '0;
         over_q  <= 1'b0;
         rows_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         x_q     <= x_d;
         y_q     <= y_d;
         k_q     <= k_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         lines_q <= lines_d;
         over_q  <= over_d;
         rows_q  <= rows_d;
      end
   end

   always_comb begin
      field_o = '1;
      for (int r = 0; r < ROWS; r++) field_o[r*(COLS+1) +: COLS] = rows_q[r];
   end

   assign busy_o      = (state_q == StMerge) || (state_q == StScan) || (state_q == StShift);
   assign done_o      = (state_q == StDone);
   assign lines_o     = lines_q;
   assign game_over_o = over_q;

endmodule

// File: tb/tb_field_lock.sv
// Bench for field_lock: directed scenarios plus random locks against a row-compaction model.
module tb_field_lock;

   localparam int ROWS  = 20;
   localparam int COLS  = 10;
   localparam int COL_W = 4;
   localparam int ROW_W = 5;
   localparam int FW    = (ROWS+1)*(COLS+1);

   typedef logic [COLS-1:0] row_t;

   logic             clk;
   logic             rst_n;
   logic             lock_req;
   logic             clear_req;
   logic [15:0]      b_mask;
   logic [COL_W:0]   b_x;
   logic [ROW_W:0]   b_y;
   logic [FW-1:0]    field_o;
   logic             busy_o;
   logic             done_o;
   logic [2:0]       lines_o;
   logic             game_over_o;

   int n_cmp = 0;
   int n_bad = 0;

   row_t m_rows [ROWS];
   logic m_over;
   int   m_lines;

   field_lock #(
      .ROWS (ROWS),
      .COLS (COLS),
      .COL_W(COL_W),
      .ROW_W(ROW_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lock_req   (lock_req),
      .clear_req  (clear_req),
      .b_mask     (b_mask),
      .b_x        (b_x),
      .b_y        (b_y),
      .field_o    (field_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .lines_o    (lines_o),
      .game_over_o(game_over_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
      m_over  = 1'b0;
      m_lines = 0;
   endtask

   // Place every brick, then drop all full rows at once by compacting the survivors downward.
   task automatic model_lock(input logic [15:0] m, input int x, input int y, output int n);
      row_t kept[$];
      int   r;
      int   c;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (m[4*i+j]) begin
               r = y + i;
               c = x + j;
               if (r < 0) m_over = 1'b1;
               else if (r < ROWS && c >= 0 && c < COLS) m_rows[r][c] = 1'b1;
            end
         end
      end
      for (int rr = ROWS-1; rr >= 0; rr--) begin
         if (&m_rows[rr]) n++;
         else kept.push_back(m_rows[rr]);
      end
      for (int rr = ROWS-1; rr >= 0; rr--) begin
         if (kept.size() > 0) m_rows[rr] = kept.pop_front();
         else m_rows[rr] = '0;
      end
      m_lines = n;
   endtask

   function automatic logic [FW-1:0] model_field();
      logic [FW-1:0] f;
      f = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            f[r*(COLS+1)+c] = m_rows[r][c];
      return f;
   endfunction

   task automatic do_clear();
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      model_clear();
      check("clear_field", field_o, model_field());
   endtask

   task automatic do_lock(input logic [15:0] m, input int x, input int y, input int repulse);
      int n;
      int cyc;
      int busy_bad;
      int extra;
      model_lock(m, x, y, n);
      @(negedge clk);
      b_mask   = m;
      b_x      = (COL_W+1)'(x);
      b_y      = (ROW_W+1)'(y);
      lock_req = 1'b1;
      @(negedge clk);
      lock_req = 1'b0;
      cyc      = 1;
      busy_bad = 0;
      while (!done_o && cyc < 100) begin
         if (!busy_o) busy_bad++;
         if (cyc == repulse) begin
            lock_req = 1'b1;
            b_mask   = 16'hFFFF;
         end
         @(negedge clk);
         lock_req = 1'b0;
         cyc++;
      end
      check("latency", FW'(cyc), FW'(17 + ROWS + 2*n));
      check("busy_during", FW'(busy_bad), FW'(0));
      check("busy_at_done", FW'(busy_o), FW'(0));
      check("lines", FW'(lines_o), FW'(n));
      check("game_over", FW'(game_over_o), FW'(m_over));
      @(negedge clk);
      check("done_pulse", FW'(done_o), FW'(0));
      check("field", field_o, model_field());
      check("lines_held", FW'(lines_o), FW'(m_lines));
      if (repulse > 0) begin
         extra = 0;
         for (int t = 0; t < 50; t++) begin
            if (done_o || busy_o) extra++;
            @(negedge clk);
         end
         check("no_second_lock", FW'(extra), FW'(0));
      end
   endtask

   initial begin
      int cnt;
      int x;
      int y;
      logic [15:0] m;

      rst_n     = 1'b0;
      lock_req  = 1'b0;
      clear_req = 1'b0;
      b_mask    = '0;
      b_x       = '0;
      b_y       = '0;
      model_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst_field", field_o, model_field());
      check("rst_busy", FW'(busy_o), FW'(0));
      check("rst_done", FW'(done_o), FW'(0));
      check("rst_lines", FW'(lines_o), FW'(0));
      check("rst_over", FW'(game_over_o), FW'(0));

      // Horizontal I on the floor
      do_lock(16'h000F, 3, 19, 0);

      // Single line clear with a brick above that must drop
      do_clear();
      do_lock(16'h0001, 2, 18, 0);
      do_lock(16'h000F, 0, 19, 0);
      do_lock(16'h0003, 4, 19, 0);
      do_lock(16'h0001, 9, 19, 0);
      do_lock(16'h0007, 6, 19, 0);
      check("dropped_brick", FW'(field_o[(COLS+1)*19+2]), FW'(1));
      check("wall_bit", FW'(field_o[(COLS+1)*5+COLS]), FW'(1));

      // Four lines
      do_clear();
      do_lock(16'hFFFF, 0, 16, 0);
      do_lock(16'hFFFF, 4, 16, 0);
      do_lock(16'h1111, 8, 16, 0);
      do_lock(16'h1111, 9, 16, 0);

      // Above the top: game over, only row 0 written; stays sticky
      do_clear();
      do_lock(16'h0033, 4, -1, 0);
      do_lock(16'h0001, 0, 5, 0);
      do_clear();
      check("over_cleared", FW'(game_over_o), FW'(0));

      // Abort by clear_req at cycle 10, then a lock 2 cycles later
      do_lock(16'h000F, 0, 19, 0);
      @(negedge clk);
      b_mask   = 16'h00FF;
      b_x      = 5'd2;
      b_y      = 6'd10;
      lock_req = 1'b1;
      @(negedge clk);
      lock_req = 1'b0;
      repeat (9) @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      model_clear();
      check("abort_field", field_o, model_field());
      check("abort_busy", FW'(busy_o), FW'(0));
      check("abort_done", FW'(done_o), FW'(0));
      do_lock(16'h0033, 1, 18, 0);

      // Re-pulse while busy
      do_lock(16'h0001, 5, 10, 5);

      // lock_req and clear_req together
      @(negedge clk);
      b_mask    = 16'h000F;
      b_x       = 5'd0;
      b_y       = 6'd19;
      lock_req  = 1'b1;
      clear_req = 1'b1;
      @(negedge clk);
      lock_req  = 1'b0;
      clear_req = 1'b0;
      model_clear();
      cnt = 0;
      for (int t = 0; t < 45; t++) begin
         if (done_o || busy_o) cnt++;
         @(negedge clk);
      end
      check("both_no_lock", FW'(cnt), FW'(0));
      check("both_field", field_o, model_field());

      // Asynchronous reset mid-lock
      @(negedge clk);
      b_mask   = 16'h000F;
      b_x      = 5'd0;
      b_y      = 6'd19;
      lock_req = 1'b1;
      @(negedge clk);
      lock_req = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      check("arst_field", field_o, model_field());
      check("arst_busy", FW'(busy_o), FW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int t = 0; t < 30; t++) begin
         if (done_o) cnt++;
         @(negedge clk);
      end
      check("arst_no_done", FW'(cnt), FW'(0));

      // Random locks
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 7) == 0) do_clear();
         if ($urandom_range(0, 2) == 0) begin
            m = 16'h000F;
            x = int'($urandom_range(0, 3)) * 2;
            y = 16 + int'($urandom_range(0, 3));
         end else begin
            m = 16'($urandom) & 16'($urandom);
            x = int'($urandom_range(0, 14)) - 3;
            y = int'($urandom_range(0, 22)) - 3;
         end
         do_lock(m, x, y, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
